// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned ADDR_W  = 32;
   localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

   typedef enum logic {
      RUN,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  pc_plus4;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] x);
      return x & ~(ADDR_W'(3));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {pc+4, instr} entries with flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         clear,
   output fetch_entry_t head,
   output logic [CW-1:0] count
);

   fetch_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues credit-limited imem requests,
// buffers in-order responses for IF/ID and flushes on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned       DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               ifid_valid,
   input  logic               ifid_ready,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0]  ifid_pc_plus4,
   output logic               proto_err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_t      state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] resp_pc;
   logic [CW-1:0]     outstanding;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     fifo_count;
   logic [CW:0]       credit_used;
   logic              gnt_fire;
   logic              rsp_accept;
   logic              push;
   logic              pop;
   logic [CW-1:0]     outstanding_nxt;
   fetch_entry_t      push_data;
   fetch_entry_t      head;

   // Buffered entries plus in-flight requests never exceed DEPTH, so a
   // response always has a free slot.
   assign credit_used = {1'b0, fifo_count} + {1'b0, outstanding};
   assign imem_req    = rst & ~redirect & (credit_used < (CW+1)'(DEPTH));
   assign imem_addr   = fetch_pc;

   assign gnt_fire        = imem_req & imem_gnt;
   assign rsp_accept      = imem_rvalid & (outstanding != '0);
   assign outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(rsp_accept);

   assign push      = rsp_accept & ~redirect & (state == RUN);
   assign pop       = ifid_valid & ifid_ready & ~redirect;
   assign push_data = '{pc_plus4: resp_pc + 32'd4, instr: imem_rdata};

   assign ifid_valid    = (fifo_count != '0);
   assign ifid_instr    = head.instr;
   assign ifid_pc_plus4 = head.pc_plus4;

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_data),
      .pop      (pop),
      .clear    (redirect),
      .head     (head),
      .count    (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         proto_err   <= 1'b0;
      end else begin
         outstanding <= outstanding_nxt;
         if (imem_rvalid && outstanding == '0) begin
            proto_err <= 1'b1;
         end
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc <= align_pc(redirect_pc);
            resp_pc  <= align_pc(redirect_pc);
            drop_cnt <= outstanding_nxt;
            state    <= (outstanding_nxt != '0) ? DRAIN : RUN;
         end else begin
            if (gnt_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
               resp_pc <= resp_pc + 32'd4;
            end
            if (rsp_accept && state == DRAIN) begin
               drop_cnt <= drop_cnt - CW'(1);
               if (drop_cnt == CW'(1)) begin
                  state <= RUN;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirect, grant stall, reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic        ifid_ready;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic        proto_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC(32'h0000_3000),
      .DEPTH   (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .ifid_valid   (ifid_valid),
      .ifid_ready   (ifid_ready),
      .ifid_instr   (ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4),
      .proto_err    (proto_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(imem_req), 32'd0);
      chk({tag, "_addr"},  imem_addr, 32'h0000_3000);
      chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
      chk({tag, "_instr"}, ifid_instr, 32'd0);
      chk({tag, "_pc4"},   ifid_pc_plus4, 32'd0);
      chk({tag, "_perr"},  32'(proto_err), 32'd0);
   endtask

   initial begin
      rst = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; ifid_ready = 1'b0;
      step(); step();
      chk_reset_vals("rst0");
      rst = 1'b1;

      // Streaming
      imem_gnt = 1'b1; ifid_ready = 1'b1; #1;
      chk("s_req0", 32'(imem_req), 32'd1);
      chk("s_addr0", imem_addr, 32'h3000);
      step();
      imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_3000; #1;
      chk("s_addr1", imem_addr, 32'h3004);
      chk("s_val1", 32'(ifid_valid), 32'd0);
      step();
      imem_rdata = 32'hC0DE_3004; #1;
      chk("s_req2", 32'(imem_req), 32'd0);
      chk("s_val2", 32'(ifid_valid), 32'd1);
      chk("s_pc4_2", ifid_pc_plus4, 32'h3004);
      chk("s_ins2", ifid_instr, 32'hC0DE_3000);
      step();
      imem_rvalid = 1'b0; #1;
      chk("s_req3", 32'(imem_req), 32'd1);
      chk("s_addr3", imem_addr, 32'h3008);
      chk("s_pc4_3", ifid_pc_plus4, 32'h3008);
      chk("s_ins3", ifid_instr, 32'hC0DE_3004);
      step();
      imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_3008; #1;
      chk("s_val4", 32'(ifid_valid), 32'd0);
      chk("s_addr4", imem_addr, 32'h300C);
      step();

      // Backpressure
      imem_rdata = 32'hC0DE_300C; ifid_ready = 1'b0; #1;
      chk("b_pc4_0", ifid_pc_plus4, 32'h300C);
      chk("b_ins0", ifid_instr, 32'hC0DE_3008);
      chk("b_req0", 32'(imem_req), 32'd0);
      step();
      imem_rvalid = 1'b0; #1;
      chk("b_req1", 32'(imem_req), 32'd0);
      chk("b_pc4_1", ifid_pc_plus4, 32'h300C);
      step();
      chk("b_req2", 32'(imem_req), 32'd0);
      chk("b_pc4_2", ifid_pc_plus4, 32'h300C);
      chk("b_val2", 32'(ifid_valid), 32'd1);
      ifid_ready = 1'b1;
      step();
      chk("b_pc4_3", ifid_pc_plus4, 32'h3010);
      chk("b_ins3", ifid_instr, 32'hC0DE_300C);
      chk("b_req3", 32'(imem_req), 32'd1);
      chk("b_addr3", imem_addr, 32'h3010);
      step();
      chk("b_val4", 32'(ifid_valid), 32'd0);
      chk("b_addr4", imem_addr, 32'h3014);
      step();

      // Redirect with two outstanding
      chk("r_req0", 32'(imem_req), 32'd0);
      redirect = 1'b1; redirect_pc = 32'h0000_3041; #1;
      chk("r_req_redir", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0001; #1;
      chk("r_req1", 32'(imem_req), 32'd0);
      chk("r_val1", 32'(ifid_valid), 32'd0);
      step();
      imem_rdata = 32'hDEAD_0002; #1;
      chk("r_val2", 32'(ifid_valid), 32'd0);
      chk("r_req2", 32'(imem_req), 32'd1);
      chk("r_addr2", imem_addr, 32'h3040);
      step();

      // Grant stall on 0x3044 for three cycles
      imem_gnt = 1'b0; imem_rdata = 32'hC0DE_3040; #1;
      chk("g_val0", 32'(ifid_valid), 32'd0);
      chk("g_perr0", 32'(proto_err), 32'd0);
      chk("g_req0", 32'(imem_req), 32'd1);
      chk("g_addr0", imem_addr, 32'h3044);
      step();
      imem_rvalid = 1'b0; #1;
      chk("g_val1", 32'(ifid_valid), 32'd1);
      chk("g_pc4_1", ifid_pc_plus4, 32'h3044);
      chk("g_ins1", ifid_instr, 32'hC0DE_3040);
      chk("g_req1", 32'(imem_req), 32'd1);
      chk("g_addr1", imem_addr, 32'h3044);
      step();
      chk("g_val2", 32'(ifid_valid), 32'd0);
      chk("g_req2", 32'(imem_req), 32'd1);
      chk("g_addr2", imem_addr, 32'h3044);
      step();
      imem_gnt = 1'b1; #1;
      chk("g_req3", 32'(imem_req), 32'd1);
      chk("g_addr3", imem_addr, 32'h3044);
      step();
      chk("g_req4", 32'(imem_req), 32'd1);
      chk("g_addr4", imem_addr, 32'h3048);
      step();
      imem_gnt = 1'b0; #1;
      chk("g_req5", 32'(imem_req), 32'd0);

      // Redirect, response and pop in the same cycle
      imem_rvalid = 1'b1; imem_rdata = 32'hC0DE_3044;
      step();
      chk("x_val0", 32'(ifid_valid), 32'd1);
      chk("x_pc4_0", ifid_pc_plus4, 32'h3048);
      chk("x_ins0", ifid_instr, 32'hC0DE_3044);
      redirect = 1'b1; redirect_pc = 32'h0000_5002; imem_rdata = 32'hC0DE_3048; #1;
      chk("x_req0", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0; imem_rvalid = 1'b0; #1;
      chk("x_val1", 32'(ifid_valid), 32'd0);
      chk("x_req1", 32'(imem_req), 32'd1);
      chk("x_addr1", imem_addr, 32'h5000);
      chk("x_perr1", 32'(proto_err), 32'd0);
      imem_gnt = 1'b1;
      step();
      imem_gnt = 1'b0; #1;
      chk("x_val2", 32'(ifid_valid), 32'd0);
      chk("x_addr2", imem_addr, 32'h5004);

      // Async reset with one request outstanding
      #2 rst = 1'b0;
      #1;
      chk_reset_vals("arst");
      step();
      rst = 1'b1; #1;
      chk("a_req0", 32'(imem_req), 32'd1);
      chk("a_addr0", imem_addr, 32'h3000);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000;
      step();
      imem_rvalid = 1'b0; #1;
      chk("a_perr1", 32'(proto_err), 32'd1);
      chk("a_val1", 32'(ifid_valid), 32'd0);
      step();
      chk("a_perr2", 32'(proto_err), 32'd1);
      chk("a_val2", 32'(ifid_valid), 32'd0);
      chk("a_addr2", imem_addr, 32'h3000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake that tolerates variable latency.
- Buffers returned instructions with their PC+4 in a small FIFO, presented to IF/ID with valid/ready.
- Accepts redirects (taken branch/jump/jr) that flush in-flight and buffered instructions.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- DEPTH, 2, prefetch FIFO entries; also the max outstanding requests (power of 2, ≥2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of request, bits[1:0] always 0.
- imem_gnt  in  1  request accepted this cycle (with imem_req).
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits[1:0] ignored and forced 0.
- ifid_valid  out  1  head FIFO entry valid.
- ifid_ready  in  1  IF/ID consumes head (low when STALL).
- ifid_instr  out  32  head instruction.
- ifid_pc_plus4  out  32  head instruction address + 4.
- proto_err  out  1  sticky: rvalid seen with no request outstanding.

Behaviour:
- Reset (rst low, async):
  - fetch_pc = resp_pc = RESET_PC.
  - outstanding, drop_cnt and FIFO count = 0.
  - imem_req = 0, imem_addr = RESET_PC.
  - ifid_valid = 0, ifid_instr = 0, ifid_pc_plus4 = 0.
  - proto_err = 0.
- Reset mid-operation discards everything; in-flight responses are not tracked across reset.
- Request issue:
  - imem_req = !redirect && (count + outstanding < DEPTH).
  - imem_addr = fetch_pc.
  - req & gnt: fetch_pc += 4 (wraps modulo 2^32), outstanding += 1.
  - req & !gnt: imem_req stays high and imem_addr stays stable until gnt or redirect.
- Response:
  - rvalid with drop_cnt > 0: discard, drop_cnt -= 1, outstanding -= 1.
  - rvalid with drop_cnt == 0 and outstanding > 0: push {resp_pc + 4, imem_rdata}, resp_pc += 4, outstanding -= 1.
  - rvalid with outstanding == 0: ignore, set proto_err.
- Latency:
  - gnt at cycle t; rvalid no earlier than t+1.
  - Entry is visible on ifid_* the cycle after rvalid (registered FIFO, no bypass).
- Pop: ifid_valid & ifid_ready on a rising edge removes the head. Push and pop in the same cycle keep count unchanged.
- Full/empty:
  - Credit rule guarantees no push when full.
  - ifid_valid = (count != 0).
  - ifid_instr/ifid_pc_plus4 hold their last value when empty (don't-care).
- Redirect (takes priority over all same-cycle events):
  - Next cycle: fetch_pc = resp_pc = redirect_pc & ~3, FIFO cleared, ifid_valid = 0.
  - drop_cnt = outstanding after this cycle's grant and response are counted. A grant this cycle cannot occur because imem_req is low; a response this cycle is discarded.
  - A same-cycle pop is irrelevant.
  - Redirect held for multiple cycles: each cycle re-applies it; no requests are issued until redirect falls.
- FSM states:
  - RUN: normal operation.
  - DRAIN: drop_cnt > 0; new requests may still issue and are not dropped.
  - DRAIN→RUN when drop_cnt reaches 0.
  - Order is preserved because responses return in order.
- Counters sized for 0..DEPTH; no overflow by construction.

Decomposition:
- Package fetch_pkg: RESET_PC default, INSTR_W=32, ADDR_W=32, NOP=32'h0000_0000, function align_pc(x) = x & ~3.
- One sub-module: fetch_fifo, a synchronous FIFO of DEPTH×64 with push/pop/clear/count and async active-low reset.

Test Plan:
1. Streaming: reset release, gnt=1, rvalid 1 cycle after gnt, ready=1 -> imem_addr 0x3000, 0x3004, 0x3008…; ifid_pc_plus4 0x3004 with the word at 0x3000 two cycles after first gnt; one instruction per cycle thereafter.
2. Backpressure: ready=0 -> after 2 responses imem_req=0, ifid_pc_plus4 holds 0x3004; ready=1 -> 0x3004, 0x3008 pop and fetch resumes at 0x3008.
3. Redirect with 2 outstanding to 0x3041 -> both responses discarded, next imem_addr 0x3040, first ifid_pc_plus4 0x3044, proto_err=0.
4. Grant stall: gnt low 3 cycles -> imem_req high and imem_addr 0x3000 stable for 4 cycles; exactly one request is counted.
5. Simultaneous: redirect, rvalid and ifid pop in one cycle -> FIFO empty next cycle, response dropped, fetch restarts at redirect_pc.
6. Async reset mid-stream with 1 outstanding -> outputs return to reset values without a clock edge; a stray rvalid after release sets proto_err=1 and pushes nothing.
